// File: rtl/lcd_string_gen.sv
// Character source for the LCD write sequencer: a writable static-text buffer with a live
// HH:MM:SS BCD clock overlay (12h/AM-PM, edit blink, invalid-digit marking), read via req/valid.
module lcd_string_gen #(
  parameter int NUM_FIELDS = 3,
  parameter int COLS       = 16,
  parameter int ROWS       = 2,
  parameter int TIME_ROW   = 1,
  parameter int TIME_COL   = 0,
  parameter int BLINK_HALF = 25000000,
  parameter int IDX_W      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*NUM_FIELDS-1:0] bcd,
  input  logic                    mode_12h,
  input  logic                    edit_en,
  input  logic [3:0]              edit_field,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [7:0]              wr_data,
  input  logic                    rd_req,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic                    rd_valid,
  output logic [7:0]              rd_char
);

  localparam int DEPTH  = ROWS * COLS;
  localparam int BASE   = TIME_ROW * COLS + TIME_COL;
  localparam int SUFFIX = 3 * NUM_FIELDS - 1;
  localparam int CNT_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

  if (TIME_COL + 3 * NUM_FIELDS + 2 > COLS) begin : gBadOverlay
    $error("lcd_string_gen: time overlay does not fit in a row");
  end
  if ((1 << IDX_W) < DEPTH) begin : gBadIdx
    $error("lcd_string_gen: IDX_W too narrow for ROWS*COLS");
  end

  logic [7:0]       mem_q [DEPTH];
  logic             valid_q;
  logic [7:0]       char_q, char_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  logic [3:0] hT, hO;
  int         idxI, off, hVal, hDisp;
  logic       hBad, blinkOn;
  logic [7:0] hrTensC, hrOnesC, tC, oC;

  function automatic logic [7:0] digitChar(input logic [3:0] n);
    return (n > 4'd9) ? 8'h3F : {4'h3, n};
  endfunction

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!edit_en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = !phase_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Hours field remapped for 12h display; any bad nibble or hour > 23 shows as "??".
  always_comb begin
    hT      = bcd[8*NUM_FIELDS-1 -: 4];
    hO      = bcd[8*NUM_FIELDS-5 -: 4];
    hVal    = 10 * int'(hT) + int'(hO);
    hBad    = (hT > 4'd9) || (hO > 4'd9) || (hVal > 23);
    hDisp   = (hVal == 0) ? 12 : (hVal > 12) ? hVal - 12 : hVal;
    hrTensC = hBad ? 8'h3F : ((hDisp >= 10) ? 8'h31 : 8'h30);
    hrOnesC = hBad ? 8'h3F : 8'h30 + 8'((hDisp >= 10) ? hDisp - 10 : hDisp);
  end

  always_comb begin
    idxI    = int'(rd_idx);
    off     = idxI - BASE;
    blinkOn = edit_en && phase_q;
    tC      = 8'h20;
    oC      = 8'h20;
    char_d  = 8'h20;
    if (idxI < DEPTH) char_d = mem_q[rd_idx];
    for (int k = 0; k < NUM_FIELDS; k++) begin
      tC = digitChar(bcd[8*(NUM_FIELDS-1-k)+4 +: 4]);
      oC = digitChar(bcd[8*(NUM_FIELDS-1-k) +: 4]);
      if (k == 0 && mode_12h) begin
        tC = hrTensC;
        oC = hrOnesC;
      end
      if (blinkOn && int'(edit_field) == NUM_FIELDS - 1 - k) begin
        tC = 8'h20;
        oC = 8'h20;
      end
      if (off == 3 * k)     char_d = tC;
      if (off == 3 * k + 1) char_d = oC;
      if (k < NUM_FIELDS - 1 && off == 3 * k + 2) char_d = 8'h3A;
    end
    if (mode_12h) begin
      if (off == SUFFIX)     char_d = 8'h20;
      if (off == SUFFIX + 1) char_d = hBad ? 8'h2D : ((hVal >= 12) ? 8'h50 : 8'h41);
      if (off == SUFFIX + 2) char_d = hBad ? 8'h2D : 8'h4D;
    end
  end

  // The read mux samples mem_q before this edge's write lands, so a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      char_q  <= 8'h00;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h20;
    end else begin
      valid_q <= rd_req;
      if (rd_req) char_q <= char_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      if (wr_en && int'(wr_idx) < DEPTH) mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q;
  assign rd_char  = char_q;

endmodule

// File: tb/tb_lcd_string_gen.sv
// Directed bench for lcd_string_gen (BLINK_HALF=4) with a per-cycle reference model of the
// display contents plus literal spot checks.
module tb_lcd_string_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] bcdIn = 24'h235958;
  logic        mode12 = 1'b0;
  logic        editEn = 1'b0;
  logic [3:0]  editField = 4'd0;
  logic        wrEn = 1'b0;
  logic [4:0]  wrIdx = 5'd0;
  logic [7:0]  wrData = 8'h00;
  logic        rdReq = 1'b0;
  logic [4:0]  rdIdx = 5'd0;
  logic        rdValid;
  logic [7:0]  rdChar;

  int vecCount = 0;
  int missCount = 0;

  lcd_string_gen #(.BLINK_HALF(4)) dut (
    .clk(clk), .rst(rst), .bcd(bcdIn), .mode_12h(mode12), .edit_en(editEn),
    .edit_field(editField), .wr_en(wrEn), .wr_idx(wrIdx), .wr_data(wrData),
    .rd_req(rdReq), .rd_idx(rdIdx), .rd_valid(rdValid), .rd_char(rdChar)
  );

  always #5 clk = ~clk;

  // Reference model: display line rebuilt from the rules every request.
  logic [7:0] modelMem [32];
  int         elapsed;
  logic       expValid;
  logic [7:0] expChar;
  int         lastIdx;

  function automatic logic [7:0] digitOf(input logic [3:0] n);
    if (n > 9) return 8'h3F;
    return 8'h30 + 8'(n);
  endfunction

  function automatic logic [7:0] modelChar(input int idx);
    logic [7:0] ov [11];
    logic [3:0] t, o;
    int         h, hd, f;
    bit         bad, blank;
    if (idx >= 32) return 8'h20;
    if (idx < 16 || idx > 26) return modelMem[idx];
    for (int i = 0; i < 11; i++) ov[i] = modelMem[16 + i];
    h   = 10 * int'(bcdIn[23:20]) + int'(bcdIn[19:16]);
    bad = (bcdIn[23:20] > 9) || (bcdIn[19:16] > 9) || (h > 23);
    for (int k = 0; k < 3; k++) begin
      f = 2 - k;
      t = bcdIn[8*f+4 +: 4];
      o = bcdIn[8*f +: 4];
      ov[3*k]   = digitOf(t);
      ov[3*k+1] = digitOf(o);
      if (f == 2 && mode12) begin
        hd = (h % 12 == 0) ? 12 : h % 12;
        ov[3*k]   = bad ? 8'h3F : 8'h30 + 8'(hd / 10);
        ov[3*k+1] = bad ? 8'h3F : 8'h30 + 8'(hd % 10);
      end
      blank = editEn && ((elapsed / 4) % 2 == 1) && (int'(editField) == f);
      if (blank) begin
        ov[3*k]   = 8'h20;
        ov[3*k+1] = 8'h20;
      end
      if (k < 2) ov[3*k+2] = 8'h3A;
    end
    if (mode12) begin
      ov[8]  = 8'h20;
      ov[9]  = bad ? 8'h2D : ((h >= 12) ? 8'h50 : 8'h41);
      ov[10] = bad ? 8'h2D : 8'h4D;
    end
    return ov[idx - 16];
  endfunction

  always begin
    @(posedge clk);
    if (rst) begin
      expValid = 1'b0;
      expChar  = 8'h00;
      elapsed  = 0;
      for (int i = 0; i < 32; i++) modelMem[i] = 8'h20;
    end else begin
      expValid = rdReq;
      if (rdReq) begin
        expChar = modelChar(int'(rdIdx));
        lastIdx = int'(rdIdx);
      end
      if (wrEn) modelMem[wrIdx] = wrData;
      elapsed = editEn ? elapsed + 1 : 0;
    end
    #1;
    vecCount++;
    if (rdValid !== expValid || rdChar !== expChar) begin
      missCount++;
      $display("[TB] FAIL model idx=%0d t=%0t: got valid=%b char=%h, expected valid=%b char=%h",
               lastIdx, $time, rdValid, rdChar, expValid, expChar);
    end
  end

  task automatic applyStimulus(input bit rq, input int idx, input bit we, input int widx,
                               input logic [7:0] wd);
    @(negedge clk);
    rdReq  = rq;
    rdIdx  = 5'(idx);
    wrEn   = we;
    wrIdx  = 5'(widx);
    wrData = wd;
  endtask

  task automatic checkOutput(input string name, input bit expV, input logic [7:0] expC);
    @(posedge clk);
    #1;
    vecCount++;
    if (rdValid !== expV || rdChar !== expC) begin
      missCount++;
      $display("[TB] FAIL %s: got valid=%b char=%h, expected valid=%b char=%h",
               name, rdValid, rdChar, expV, expC);
    end
  endtask

  task automatic readExpect(input string name, input int idx, input logic [7:0] expC);
    applyStimulus(1'b1, idx, 1'b0, 0, 8'h00);
    checkOutput(name, 1'b1, expC);
  endtask

  logic [7:0] timeStr [8] = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h38};
  logic [7:0] hello   [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
  logic [7:0] expB;

  initial begin
    applyStimulus(1'b0, 0, 1'b0, 0, 8'h00);
    checkOutput("reset", 1'b0, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      expB = (i >= 16 && i < 24) ? timeStr[i-16] : 8'h20;
      readExpect($sformatf("t1 idx%0d", i), i, expB);
    end
    readExpect("t1 idx23 again", 23, 8'h38);
    applyStimulus(1'b0, 0, 1'b0, 0, 8'h00);
    checkOutput("t1 idle hold", 1'b0, 8'h38);

    mode12 = 1'b1;
    bcdIn  = 24'h005958;
    readExpect("t2 h00 tens", 16, 8'h31);
    readExpect("t2 h00 ones", 17, 8'h32);
    readExpect("t2 sp", 24, 8'h20);
    readExpect("t2 A", 25, 8'h41);
    readExpect("t2 M", 26, 8'h4D);
    bcdIn = 24'h135958;
    readExpect("t2 h13 tens", 16, 8'h30);
    readExpect("t2 h13 ones", 17, 8'h31);
    readExpect("t2 h13 P", 25, 8'h50);
    bcdIn = 24'h125958;
    readExpect("t2 h12 tens", 16, 8'h31);
    readExpect("t2 h12 ones", 17, 8'h32);
    readExpect("t2 h12 P", 25, 8'h50);
    mode12 = 1'b0;
    for (int i = 24; i < 27; i++) readExpect($sformatf("t2 24h idx%0d", i), i, 8'h20);

    bcdIn = 24'h23595A;
    readExpect("t3 bad sec ones", 23, 8'h3F);
    readExpect("t3 sec tens", 22, 8'h35);
    mode12 = 1'b1;
    bcdIn  = 24'h245958;
    readExpect("t3 h24 tens", 16, 8'h3F);
    readExpect("t3 h24 ones", 17, 8'h3F);
    readExpect("t3 h24 sp", 24, 8'h20);
    readExpect("t3 h24 dash1", 25, 8'h2D);
    readExpect("t3 h24 dash2", 26, 8'h2D);
    mode12 = 1'b0;
    bcdIn  = 24'h235958;

    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 0, 1'b1, i, hello[i]);
    for (int i = 0; i < 5; i++) readExpect($sformatf("t4 hello%0d", i), i, hello[i]);
    applyStimulus(1'b0, 0, 1'b1, 16, 8'h41);
    readExpect("t4 overlay masks write", 16, 8'h32);
    applyStimulus(1'b1, 5, 1'b1, 5, 8'h5A);
    checkOutput("t4 same-cycle old", 1'b1, 8'h20);
    readExpect("t4 new value", 5, 8'h5A);
    applyStimulus(1'b0, 0, 1'b1, 24, 8'h2A);
    readExpect("t4 24h buffer idx24", 24, 8'h2A);
    mode12 = 1'b1;
    readExpect("t4 12h masks idx24", 24, 8'h20);
    mode12 = 1'b0;

    for (int j = 0; j < 16; j++) begin
      applyStimulus(1'b1, (j % 2 == 1) ? 20 : 19, 1'b0, 0, 8'h00);
      if (j == 0) begin
        editEn    = 1'b1;
        editField = 4'd1;
      end
      if ((j / 4) % 2 == 0) expB = (j % 2 == 1) ? 8'h39 : 8'h35;
      else expB = 8'h20;
      checkOutput($sformatf("t5 blink j%0d", j), 1'b1, expB);
    end
    readExpect("t5 colon18", 18, 8'h3A);
    readExpect("t5 colon21", 21, 8'h3A);
    editField = 4'd3;
    for (int j = 18; j < 26; j++) readExpect($sformatf("t5 nofield j%0d", j), 19, 8'h35);
    editField = 4'd1;
    readExpect("t5 j26 visible", 19, 8'h35);
    readExpect("t5 j27 visible", 19, 8'h35);
    readExpect("t5 j28 blank", 19, 8'h20);
    editEn = 1'b0;
    readExpect("t5 edit off visible", 19, 8'h35);

    readExpect("t6 pre0", 0, 8'h48);
    readExpect("t6 pre1", 1, 8'h45);
    applyStimulus(1'b1, 2, 1'b0, 0, 8'h00);
    rst = 1'b1;
    checkOutput("t6 rst drop", 1'b0, 8'h00);
    applyStimulus(1'b0, 0, 1'b0, 0, 8'h00);
    rst = 1'b0;
    checkOutput("t6 after rst", 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) readExpect($sformatf("t6 cleared%0d", i), i, 8'h20);
    applyStimulus(1'b0, 0, 1'b0, 0, 8'h00);
    checkOutput("t6 final idle", 1'b0, 8'h20);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
